// File: rtl/m_calc_ctrl.sv
// m_calc_ctrl: sequences A, B and opcode entry words into an external ALU and
// holds the captured result until the consumer acknowledges it.
module m_calc_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din_i,
   input  logic       din_vld_i,
   output logic       din_rdy_o,
   input  logic       clr_i,
   output logic [7:0] alu_a_o,
   output logic [7:0] alu_b_o,
   output logic [3:0] alu_sel_o,
   input  logic [7:0] alu_res_i,
   input  logic [3:0] alu_flag_i,
   output logic [7:0] res_o,
   output logic [3:0] flag_o,
   output logic       res_vld_o,
   input  logic       res_ack_i,
   output logic       err_o,
   output logic [7:0] op_cnt_o
);
   typedef enum logic [2:0] {IDLE, GET_B, GET_OP, EXEC, DONE} state_t;
   state_t     state_q, state_d;
   logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d, cnt_q, cnt_d;
   logic [3:0] op_q, op_d, flag_q, flag_d;
   logic       err_q, err_d, accept;

   assign din_rdy_o = (state_q == IDLE) || (state_q == GET_B) || (state_q == GET_OP);
   assign accept    = din_vld_i && din_rdy_o;
   assign alu_a_o   = a_q;
   assign alu_b_o   = b_q;
   assign alu_sel_o = (state_q == EXEC) ? op_q : 4'hF;
   assign res_o     = res_q;
   assign flag_o    = flag_q;
   assign res_vld_o = (state_q == DONE);
   assign err_o     = err_q;
   assign op_cnt_o  = cnt_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      flag_d  = flag_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         state_d = IDLE;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               a_d     = din_i;
               state_d = GET_B;
            end
            GET_B: if (accept) begin
               b_d     = din_i;
               state_d = GET_OP;
            end
            GET_OP: if (accept) begin
               // Rejected requests report straight from here, bypassing EXEC.
               if (din_i > 8'h0B) begin
                  res_d   = 8'h00;
                  flag_d  = 4'h0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (din_i[3:0] == 4'h3 && b_q == 8'h00) begin
                  res_d   = 8'hFF;
                  flag_d  = 4'h0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  op_d    = din_i[3:0];
                  state_d = EXEC;
               end
            end
            EXEC: begin
               res_d   = alu_res_i;
               flag_d  = alu_flag_i;
               err_d   = 1'b0;
               cnt_d   = cnt_q + 8'd1;
               state_d = DONE;
            end
            DONE: if (res_ack_i) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         op_q    <= 4'h0;
         res_q   <= 8'h00;
         flag_q  <= 4'h0;
         err_q   <= 1'b0;
         cnt_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         flag_q  <= flag_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_m_calc_ctrl.sv
// tb_m_calc_ctrl: directed scenarios for m_calc_ctrl with a small adder ALU
// model driving the result/flag inputs.
module tb_m_calc_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_vld = 1'b0, clr = 1'b0, res_ack = 1'b0;
   logic       din_rdy, res_vld, err;
   logic [7:0] alu_a, alu_b, alu_res, res, op_cnt;
   logic [3:0] alu_sel, alu_flag, flag;
   logic [8:0] sum9;
   logic [7:0] exp_cnt;
   int         pass = 0, total = 0;

   always #5 clk = ~clk;

   m_calc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .din_i(din), .din_vld_i(din_vld), .din_rdy_o(din_rdy),
      .clr_i(clr), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
      .alu_res_i(alu_res), .alu_flag_i(alu_flag), .res_o(res), .flag_o(flag),
      .res_vld_o(res_vld), .res_ack_i(res_ack), .err_o(err), .op_cnt_o(op_cnt)
   );

   // Op 0 adds; anything else XORs. Flags are {uf,of,cf,zf}.
   always_comb begin
      sum9     = {1'b0, alu_a} + {1'b0, alu_b};
      alu_res  = (alu_sel == 4'h0) ? sum9[7:0] : (alu_a ^ alu_b);
      alu_flag = {1'b0,
                  (alu_sel == 4'h0) && (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]),
                  (alu_sel == 4'h0) && sum9[8],
                  alu_res == 8'h00};
   end

   task automatic send(input logic [7:0] w);
      @(negedge clk);
      din = w;
      din_vld = 1'b1;
      @(posedge clk);
      #1 din_vld = 1'b0;
   endtask

   task automatic ack();
      @(negedge clk);
      res_ack = 1'b1;
      @(posedge clk);
      #1 res_ack = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++; if (din_rdy !== 1'b1) $display("FAIL rst_rdy got %h exp 1", din_rdy); else pass++;
      total++; if (alu_sel !== 4'hF) $display("FAIL rst_sel got %h exp F", alu_sel); else pass++;
      total++; if ({res_vld, err} !== 2'b00) $display("FAIL rst_vld_err got %b exp 00", {res_vld, err}); else pass++;
      total++; if ({alu_a, alu_b, res, flag, op_cnt} !== 36'h0) $display("FAIL rst_data got %h exp 0", {alu_a, alu_b, res, flag, op_cnt}); else pass++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 8'h00;
   endtask

   task automatic test_add();
      send(8'h05); send(8'h03); send(8'h00);
      total++; if ({alu_sel, res_vld} !== 5'b0000_0) $display("FAIL add_exec got sel=%h vld=%b exp sel=0 vld=0", alu_sel, res_vld); else pass++;
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 8'd1;
      total++; if (res_vld !== 1'b1) $display("FAIL add_vld got %b exp 1", res_vld); else pass++;
      total++; if ({res, flag, err} !== {8'h08, 4'h0, 1'b0}) $display("FAIL add_res got %h/%h/%b exp 08/0/0", res, flag, err); else pass++;
      total++; if (op_cnt !== exp_cnt) $display("FAIL add_cnt got %h exp %h", op_cnt, exp_cnt); else pass++;
      total++; if (alu_sel !== 4'hF) $display("FAIL add_sel_done got %h exp F", alu_sel); else pass++;
      ack();
      total++; if ({din_rdy, res_vld} !== 2'b10) $display("FAIL add_ack got %b exp 10", {din_rdy, res_vld}); else pass++;
   endtask

   task automatic test_carry();
      send(8'hFF); send(8'h01); send(8'h00);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 8'd1;
      total++; if ({res, flag} !== {8'h00, 4'b0011}) $display("FAIL carry_res got %h/%b exp 00/0011", res, flag); else pass++;
      ack();
   endtask

   task automatic test_divzero();
      send(8'h10); send(8'h00);
      total++; if (alu_sel !== 4'hF) $display("FAIL dz_sel_pre got %h exp F", alu_sel); else pass++;
      send(8'h03);
      total++; if (res_vld !== 1'b1) $display("FAIL dz_vld got %b exp 1", res_vld); else pass++;
      total++; if ({res, flag, err} !== {8'hFF, 4'h0, 1'b1}) $display("FAIL dz_res got %h/%h/%b exp FF/0/1", res, flag, err); else pass++;
      total++; if (alu_sel !== 4'hF) $display("FAIL dz_sel got %h exp F", alu_sel); else pass++;
      total++; if (op_cnt !== exp_cnt) $display("FAIL dz_cnt got %h exp %h", op_cnt, exp_cnt); else pass++;
   endtask

   task automatic test_clr_done();
      @(negedge clk);
      clr = 1'b1;
      res_ack = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      res_ack = 1'b0;
      total++; if ({res_vld, err, din_rdy} !== 3'b001) $display("FAIL clr_done got %b exp 001", {res_vld, err, din_rdy}); else pass++;
      total++; if (res !== 8'hFF) $display("FAIL clr_res_kept got %h exp FF", res); else pass++;
   endtask

   task automatic test_bad_op();
      logic [7:0] ops [2] = '{8'h0C, 8'h13};
      for (int i = 0; i < 2; i++) begin
         send(8'h21); send(8'h02); send(ops[i]);
         total++; if ({res_vld, err, res, flag} !== {1'b1, 1'b1, 8'h00, 4'h0}) $display("FAIL bad_op_%0d got %b/%b/%h/%h exp 1/1/00/0", i, res_vld, err, res, flag); else pass++;
         total++; if (op_cnt !== exp_cnt) $display("FAIL bad_cnt_%0d got %h exp %h", i, op_cnt, exp_cnt); else pass++;
         ack();
      end
   endtask

   task automatic test_rst_mid();
      send(8'h22); send(8'h33);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_cnt = 8'h00;
      total++; if ({din_rdy, alu_sel, res_vld, err} !== {1'b1, 4'hF, 2'b00}) $display("FAIL mid_rst_ctl got %b exp 1111100", {din_rdy, alu_sel, res_vld, err}); else pass++;
      total++; if ({alu_a, alu_b, res, flag, op_cnt} !== 36'h0) $display("FAIL mid_rst_data got %h exp 0", {alu_a, alu_b, res, flag, op_cnt}); else pass++;
      #2 rst_n = 1'b1;
      send(8'h44);
      @(negedge clk);
      clr = 1'b1;
      din = 8'h55;
      din_vld = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      din_vld = 1'b0;
      total++; if ({alu_a, alu_b} !== 16'h4400) $display("FAIL clr_drop got %h exp 4400", {alu_a, alu_b}); else pass++;
      send(8'h66);
      total++; if ({alu_a, alu_b} !== 16'h6600) $display("FAIL clr_idle got %h exp 6600", {alu_a, alu_b}); else pass++;
      send(8'h00); send(8'h01);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 8'd1;
      total++; if (res !== 8'h66) $display("FAIL clr_resume got %h exp 66", res); else pass++;
      ack();
   endtask

   task automatic test_hold();
      send(8'h05); send(8'h03); send(8'h00);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 8'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         din = 8'hAA;
         din_vld = 1'b1;
         total++; if ({res_vld, din_rdy, res, flag} !== {2'b10, 8'h08, 4'h0}) $display("FAIL hold_%0d got %b%b/%h/%h exp 10/08/0", i, res_vld, din_rdy, res, flag); else pass++;
      end
      din_vld = 1'b0;
      total++; if ({alu_a, alu_b} !== 16'h0503) $display("FAIL hold_ops got %h exp 0503", {alu_a, alu_b}); else pass++;
      ack();
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 256; i++) begin
         send(i[7:0]); send(8'h01); send(8'h00);
         @(posedge clk); #1;
         exp_cnt = exp_cnt + 8'd1;
         total++; if (op_cnt !== exp_cnt) $display("FAIL wrap_cnt_%0d got %h exp %h", i, op_cnt, exp_cnt); else pass++;
         ack();
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_carry();
      test_divzero();
      test_clr_done();
      test_bad_op();
      test_rst_mid();
      test_hold();
      test_wrap();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", pass, total);
      $fatal(1);
   end
endmodule
